// File: rtl/sbox_share_sched.sv
// Time-shared AES sbox bank. It serves round SubBytes (multi-beat, 16 bytes) and
// key-expansion SubWord (single beat, 4 bytes) behind valid/ready handshakes.

module sbox_lane (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y_o = TBL[a_i];
endmodule

module sbox_share_sched #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_in_valid,
  output logic         s_in_ready,
  input  logic [127:0] s_in_data,
  output logic         s_out_valid,
  input  logic         s_out_ready,
  output logic [127:0] s_out_data,
  input  logic         k_in_valid,
  output logic         k_in_ready,
  input  logic [31:0]  k_in_data,
  output logic         k_out_valid,
  input  logic         k_out_ready,
  output logic [31:0]  k_out_data,
  output logic         busy
);
  localparam int B  = 16 / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {IDLE, SUB_S, SUB_K} st_e;

  st_e             state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            last_key_q, last_key_d;
  logic [127:0]    work_q, work_d, s_data_q, s_data_d;
  logic [31:0]     k_data_q, k_data_d;
  logic            s_vld_q, s_vld_d, k_vld_q, k_vld_d;
  logic            idle, in_s, in_k, last_beat;
  logic            k_req, s_req, grant_k, grant_s;
  logic [LANES-1:0][7:0] lane_out;

  assign last_beat = (beat_q == BW'(B - 1));

  // KEY wins a tie unless it won the previous grant.
  always_comb begin
    k_req   = k_in_valid & idle & ~k_vld_q & ~rst;
    s_req   = s_in_valid & idle & ~s_vld_q & ~rst;
    grant_k = k_req & (~s_req | ~last_key_q);
    grant_s = s_req & ~grant_k;
  end

  for (genvar L = 0; L < LANES; L++) begin : g_lane
    localparam bit KLANE = (L < 4);
    logic [6:0] sidx;
    logic [7:0] a, y;
    assign sidx = 7'(beat_q) * 7'(LANES) + 7'(L);
    assign a = in_s            ? work_q[{sidx, 3'b000} +: 8] :
               (in_k && KLANE) ? work_q[8*L +: 8] : 8'h00;
    sbox_lane u_sbox (.a_i(a), .y_o(y));
    assign lane_out[L] = y;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_k) state_d = SUB_K;
               else if (grant_s) state_d = SUB_S;
      SUB_K:   state_d = IDLE;
      SUB_S:   if (last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idle = (state_q == IDLE);
    in_s = (state_q == SUB_S);
    in_k = (state_q == SUB_K);
    busy = ~idle;
  end

  always_comb begin
    work_d     = work_q;
    beat_d     = beat_q;
    last_key_d = last_key_q;
    s_data_d   = s_data_q;
    k_data_d   = k_data_q;
    s_vld_d    = s_vld_q & ~s_out_ready;
    k_vld_d    = k_vld_q & ~k_out_ready;
    if (grant_k) begin
      work_d     = {96'h0, k_in_data};
      beat_d     = '0;
      last_key_d = 1'b1;
    end else if (grant_s) begin
      work_d     = s_in_data;
      beat_d     = '0;
      last_key_d = 1'b0;
    end
    if (in_k) begin
      for (int j = 0; j < 4; j++) k_data_d[8*j +: 8] = lane_out[j];
      k_vld_d = 1'b1;
    end
    if (in_s) begin
      for (int l = 0; l < LANES; l++)
        s_data_d[(int'(beat_q) * LANES + l) * 8 +: 8] = lane_out[l];
      beat_d = beat_q + BW'(1);
      if (last_beat) s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q     <= '0;
      beat_q     <= '0;
      last_key_q <= 1'b0;
      s_data_q   <= '0;
      k_data_q   <= '0;
      s_vld_q    <= 1'b0;
      k_vld_q    <= 1'b0;
    end else begin
      work_q     <= work_d;
      beat_q     <= beat_d;
      last_key_q <= last_key_d;
      s_data_q   <= s_data_d;
      k_data_q   <= k_data_d;
      s_vld_q    <= s_vld_d;
      k_vld_q    <= k_vld_d;
    end
  end

  assign s_in_ready  = grant_s;
  assign k_in_ready  = grant_k;
  assign s_out_valid = s_vld_q;
  assign s_out_data  = s_data_q;
  assign k_out_valid = k_vld_q;
  assign k_out_data  = k_data_q;
endmodule

// File: tb/tb_sbox_share_sched.sv
// Directed bench for sbox_share_sched: a LANES=4 instance for most scenarios and a
// LANES=16 instance that checks single-beat state latency.
module tb_sbox_share_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_in_valid = 0, s_out_ready = 0, k_in_valid = 0, k_out_ready = 0;
  logic [127:0] s_in_data = '0;
  logic [31:0]  k_in_data = '0;
  logic         s_in_ready, s_out_valid, k_in_ready, k_out_valid, busy;
  logic [127:0] s_out_data;
  logic [31:0]  k_out_data;

  logic         s16_in_valid = 0;
  logic [127:0] s16_in_data = '0;
  logic         s16_in_ready, s16_out_valid, k16_in_ready, k16_out_valid, busy16;
  logic [127:0] s16_out_data;
  logic [31:0]  k16_out_data;

  localparam logic [127:0] V  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] R  = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] S53 = {16{8'h53}};
  localparam logic [127:0] SED = {16{8'hed}};

  int ncmp = 0, nerr = 0, ng = 0;
  logic [3:0] order = '0;

  sbox_share_sched #(.LANES(4)) u4 (
    .clk(clk), .rst(rst),
    .s_in_valid(s_in_valid), .s_in_ready(s_in_ready), .s_in_data(s_in_data),
    .s_out_valid(s_out_valid), .s_out_ready(s_out_ready), .s_out_data(s_out_data),
    .k_in_valid(k_in_valid), .k_in_ready(k_in_ready), .k_in_data(k_in_data),
    .k_out_valid(k_out_valid), .k_out_ready(k_out_ready), .k_out_data(k_out_data),
    .busy(busy));

  sbox_share_sched #(.LANES(16)) u16 (
    .clk(clk), .rst(rst),
    .s_in_valid(s16_in_valid), .s_in_ready(s16_in_ready), .s_in_data(s16_in_data),
    .s_out_valid(s16_out_valid), .s_out_ready(1'b1), .s_out_data(s16_out_data),
    .k_in_valid(1'b0), .k_in_ready(k16_in_ready), .k_in_data(32'h0),
    .k_out_valid(k16_out_valid), .k_out_ready(1'b1), .k_out_data(k16_out_data),
    .busy(busy16));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick; tick;
    chk("rst_flags", {busy, s_out_valid, k_out_valid, busy16}, 4'b0);
    chk("rst_sdata", s_out_data, 128'h0);
    chk("rst_kdata", {96'h0, k_out_data}, 128'h0);
    rst = 0;

    // single key request
    k_in_valid = 1; k_in_data = 32'h00000001; #1;
    chk("k_rdy", {k_in_ready, s_in_ready}, 2'b10);
    tick; k_in_valid = 0;
    chk("k_busy", {busy, k_out_valid}, 2'b10);
    tick;
    chk("k_vld", {busy, k_out_valid}, 2'b01);
    chk("k_data", {96'h0, k_out_data}, 128'h6363637c);
    k_out_ready = 1; tick; k_out_ready = 0;
    chk("k_take", k_out_valid, 0);

    // state request on both lane widths
    s_in_valid = 1; s_in_data = V; s16_in_valid = 1; s16_in_data = V; #1;
    chk("s_rdy", {s_in_ready, s16_in_ready}, 2'b11);
    tick; s_in_valid = 0; s16_in_valid = 0;
    tick;
    chk("s16_vld", {s16_out_valid, s_out_valid, busy}, 3'b101);
    chk("s16_data", s16_out_data, R);
    tick; tick;
    chk("s4_wait", {s_out_valid, busy}, 2'b01);
    tick;
    chk("s4_vld", {s_out_valid, busy}, 2'b10);
    chk("s4_data", s_out_data, R);

    // held state result blocks only state; key still served
    s_in_valid = 1; s_in_data = S53; k_in_valid = 1; k_in_data = 32'hffffffff; #1;
    chk("hold_rdy", {s_in_ready, k_in_ready}, 2'b01);
    tick; k_in_valid = 0;
    tick;
    chk("hold_kdata", {96'h0, k_out_data}, 128'h16161616);
    chk("hold_vld", {s_out_valid, k_out_valid}, 2'b11);
    chk("hold_sdata", s_out_data, R);
    k_out_ready = 1; s_out_ready = 1; #1;
    chk("rel_srdy", s_in_ready, 0);
    tick; k_out_ready = 0; s_out_ready = 0;
    chk("rel_next", {s_out_valid, s_in_ready}, 2'b01);

    // key raised during SUB_S waits
    tick; s_in_valid = 0; k_in_valid = 1; k_in_data = 32'hffffffff; #1;
    chk("ks_wait1", k_in_ready, 0);
    tick; tick; tick;
    chk("ks_wait3", {k_in_ready, busy}, 2'b01);
    tick;
    chk("ks_grant", {k_in_ready, s_out_valid}, 2'b11);
    chk("ks_sdata", s_out_data, SED);
    tick; k_in_valid = 0;
    tick;
    chk("ks_kvld", {k_out_valid, s_out_valid}, 2'b11);
    chk("ks_kdata", {96'h0, k_out_data}, 128'h16161616);
    k_out_ready = 1; s_out_ready = 1; tick; k_out_ready = 0; s_out_ready = 0;
    chk("ks_clr", {s_out_valid, k_out_valid}, 2'b00);

    // reset in beat 2 of SUB_S
    s_in_valid = 1; s_in_data = V;
    tick; s_in_valid = 0;
    tick; tick;
    rst = 1; tick; rst = 0;
    chk("mid_rst", {busy, s_out_valid}, 2'b00);
    chk("mid_rst_data", s_out_data, 128'h0);

    // both requesters held with outputs always ready: KEY, STATE, KEY, STATE
    k_out_ready = 1; s_out_ready = 1;
    k_in_valid = 1; k_in_data = 32'hffffffff; s_in_valid = 1; s_in_data = S53;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (k_in_ready) begin order[3-ng] = 1'b1; ng++; end
      else if (s_in_ready) begin order[3-ng] = 1'b0; ng++; end
      if (k_out_valid) chk("alt_kdata", {96'h0, k_out_data}, 128'h16161616);
      if (s_out_valid) chk("alt_sdata", s_out_data, SED);
      tick;
    end
    chk("alt_cnt", ng, 4);
    chk("alt_order", order, 4'b1010);
    k_in_valid = 0; s_in_valid = 0;
    repeat (8) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
